ysyx_25060170_ifu_prefetch: RTL and testbench
=============================================

# ysyx_25060170_ifu_prefetch

Parametrised instruction-fetch unit with a decoupled memory request/response interface, in-order prefetch FIFO and redirect flushing. Holds the fetch PC, issues sequential fetches (PC+4) ahead of decode, buffers returned instructions, and hands them to the IDU via valid/ready. Branch/jump targets arrive as a single redirect from the EXU; next-PC arithmetic for branches lives in the EXU, not here.

## Interface
- XLEN, 32: address/instruction width.
- RESET_PC, 32'h8000_0000: first fetch address after reset.
- FIFO_DEPTH, 4: prefetch buffer entries; power of two, ≥2. Also the maximum number of outstanding plus buffered fetches.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  XLEN  new fetch address.
- req_valid  out  1  fetch request valid.
- req_ready  in  1  memory accepts request.
- req_addr  out  XLEN  fetch address.
- rsp_valid  in  1  response valid; responses return in request order, always accepted.
- rsp_data  in  XLEN  instruction word.
- rsp_err  in  1  access fault for this response.
- inst_valid  out  1  instruction available to the IDU.
- inst_ready  in  1  IDU consumes the head entry.
- inst  out  XLEN  instruction word.
- inst_pc  out  XLEN  address of inst.
- inst_err  out  1  access fault flag for inst.
- inst_misalign  out  1  misaligned-target flag (constant 0 without the macro).

## Operation
- Counters: pend (requests accepted, responses not yet returned), drop (returning responses to discard), cnt (FIFO occupancy); each $clog2(FIFO_DEPTH)+1 bits.
- Issue: req_valid = state==RUN & ~redirect_valid & (pend+cnt < FIFO_DEPTH). req_addr = fetch_pc. On req_valid&req_ready: fetch_pc += 4 (mod 2^XLEN, wraps silently), pend++.
- Each request also pushes its address into an address queue (same depth) so responses pair with their PC.
- Response: rsp_valid decrements pend. If drop>0, the response is discarded and drop--. Otherwise {rsp_data, addr, rsp_err} is written to the FIFO.
- Output: FIFO head drives inst/inst_pc/inst_err; inst_valid = cnt>0. Pop on inst_valid&inst_ready. Push and pop in the same cycle are both honoured; a push into a full FIFO cannot occur by construction (credit rule).
- Redirect (highest priority): FIFO and address queue are emptied; drop <= pend after this cycle's response is accounted for (a response arriving in the redirect cycle is also discarded); fetch_pc <= redirect_pc; no request handshake in the redirect cycle; an inst_ready pop in that cycle has no further effect.
- States: RUN (fetching), HALT (macro only, see Configuration). Reset -> RUN.

## Timing
- Reset values: fetch_pc=RESET_PC, pend=drop=cnt=0, state RUN; req_valid=0 while rst=0; inst_valid=0, inst/inst_pc=0, inst_err=0, inst_misalign=0.
- First cycle after reset release: req_valid=1, req_addr=RESET_PC.
- Response-to-inst_valid latency: 1 cycle (FIFO registered, no bypass).
- Redirect-to-req_valid for new target: 1 cycle.
- Back-to-back issue sustains one request per cycle while credits remain.
- Reset asserted mid-operation clears all state immediately; in-flight memory responses after reset release are not expected (memory is reset with the same signal).

## Configuration
- YSYX_25060170_IFU_MISALIGN_CHK_EN defined: a redirect with redirect_pc[1:0]!=0 enters HALT instead of fetching; one entry {inst=0, inst_pc=redirect_pc, inst_misalign=1} is pushed; no requests while in HALT; the next redirect with an aligned target returns to RUN.
- Undefined: redirect_pc[1:0] forced to 2'b00; HALT unreachable; inst_misalign tied 0.

## Structure
- Shared package: RESET_PC default, state encoding (RUN/HALT), FIFO entry field widths.
- One sub-module: ysyx_25060170_sync_fifo (parametrised width/depth, push/pop/flush, count output), instantiated for the instruction FIFO and the address queue.

## Test plan
- Reset release, memory with 1-cycle latency, inst_ready=1 -> req_addr 0x80000000, 0x80000004, 0x80000008…; inst_pc matches in order, one per cycle steady state.
- inst_ready=0, FIFO_DEPTH=4 -> exactly 4 requests issued, then req_valid=0; raise inst_ready -> issue resumes one cycle after first pop.
- 3 requests outstanding, redirect to 0x80001000 -> 3 stale responses discarded, next inst_pc=0x80001000.
- Redirect in same cycle as rsp_valid and inst_ready -> response dropped, FIFO empty next cycle, req_addr=redirect_pc.
- rsp_err=1 on address 0x80000004 -> inst_err=1 only on that entry.
- Macro on, redirect to 0x80000102 -> one entry with inst_misalign=1, no requests until aligned redirect; macro off -> fetch at 0x80000100.

Source files
------------

// File: rtl/ysyx_25060170_ifu_prefetch_pkg.sv
// Shared IFU prefetch definitions: reset PC, fetch state encoding, FIFO entry layout.
// Pure definitions; no latency or backpressure of its own.
package ysyx_25060170_ifu_prefetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  localparam int ENT_FLAG_W = 2;

  typedef struct packed {
    logic err;
    logic misalign;
  } ent_flags_t;

  // Entry layout is {inst, pc, flags}.
  function automatic int ent_w(input int xlen);
    return 2 * xlen + ENT_FLAG_W;
  endfunction

endpackage

// File: rtl/ysyx_25060170_ifu_prefetch_if.sv
// Redirect, memory request/response and IDU hand-off signals of the fetch unit.
// master = IFU side, slave = memory/EXU/IDU side.
interface ysyx_25060170_ifu_prefetch_if #(
  parameter int XLEN = 32
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_err;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_err;
  logic            inst_misalign;

  modport master (
    input  redirect_valid, redirect_pc, req_ready, rsp_valid, rsp_data, rsp_err, inst_ready,
    output req_valid, req_addr, inst_valid, inst, inst_pc, inst_err, inst_misalign
  );

  modport slave (
    output redirect_valid, redirect_pc, req_ready, rsp_valid, rsp_data, rsp_err, inst_ready,
    input  req_valid, req_addr, inst_valid, inst, inst_pc, inst_err, inst_misalign
  );
endinterface

// File: rtl/ysyx_25060170_sync_fifo.sv
// Registered FIFO with flush; a push in the flush cycle lands in the emptied FIFO.
// Head visible the cycle after push; no backpressure, caller never overfills or underflows.
module ysyx_25060170_sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  input  logic                     flush,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   cnt
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d, wr_b, rd_b;
  logic [AW:0]   cnt_q, cnt_d, cnt_b;
  logic          pop_e;

  always_comb begin
    mem_d = mem_q;
    wr_b  = flush ? '0 : wr_q;
    rd_b  = flush ? '0 : rd_q;
    cnt_b = flush ? '0 : cnt_q;
    pop_e = pop & ~flush;
    wr_d  = wr_b;
    rd_d  = pop_e ? rd_b + AW'(1) : rd_b;
    if (push) begin
      mem_d[wr_b] = push_dat;
      wr_d        = wr_b + AW'(1);
    end
    cnt_d = cnt_b + (AW+1)'(push) - (AW+1)'(pop_e);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_dat = mem_q[rd_q];
  assign cnt      = cnt_q;
endmodule

// File: rtl/ysyx_25060170_ifu_prefetch.sv
// Prefetching IFU: sequential PC+4 fetch, in-order buffer, redirect flush (misalign HALT under YSYX_25060170_IFU_MISALIGN_CHK_EN).
// Response to inst_valid 1 cycle, redirect to new request 1 cycle; issue stalls when pend+cnt reaches FIFO_DEPTH.
module ysyx_25060170_ifu_prefetch
  import ysyx_25060170_ifu_prefetch_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEF),
  parameter int              FIFO_DEPTH = 4
) (
  input logic                            clk,
  input logic                            rst,
  ysyx_25060170_ifu_prefetch_if.master   bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = ent_w(XLEN);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   pend_q, pend_d, drop_q, drop_d;
  logic [0:0]      state_q, state_d;
  logic [CW-1:0]   cnt, aq_cnt;
  logic [XLEN-1:0] aq_head, tgt;
  logic [EW-1:0]   ent_push, ent_head;
  ent_flags_t      fl_push, fl_head;
  logic            credit, req_fire, rsp_keep, aq_pop, fq_push, tgt_mis;

`ifdef YSYX_25060170_IFU_MISALIGN_CHK_EN
  assign tgt     = bus.redirect_pc;
  assign tgt_mis = |bus.redirect_pc[1:0];
`else
  assign tgt     = bus.redirect_pc & ~XLEN'(3);
  assign tgt_mis = 1'b0;
`endif

  // Credits cover both in-flight and buffered fetches, so a push never meets a full FIFO.
  assign credit        = ({1'b0, pend_q} + {1'b0, cnt}) < (CW+1)'(FIFO_DEPTH);
  assign bus.req_valid = rst & (state_q == ST_RUN) & ~bus.redirect_valid & credit;
  assign bus.req_addr  = fetch_pc_q;
  assign req_fire      = bus.req_valid & bus.req_ready;

  assign rsp_keep = bus.rsp_valid & ~bus.redirect_valid & (drop_q == '0);
  assign aq_pop   = rsp_keep & (aq_cnt != '0);
  assign fq_push  = rsp_keep | (bus.redirect_valid & tgt_mis);

  always_comb begin
    fl_push  = '{err: bus.rsp_err, misalign: 1'b0};
    ent_push = {bus.rsp_data, aq_head, fl_push};
    if (bus.redirect_valid) begin
      fl_push  = '{err: 1'b0, misalign: 1'b1};
      ent_push = {{XLEN{1'b0}}, tgt, fl_push};
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pend_d     = pend_q + CW'(req_fire) - CW'(bus.rsp_valid);
    drop_d     = drop_q;
    state_d    = state_q;
    if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
    if (bus.rsp_valid && drop_q != '0) drop_d = drop_q - CW'(1);
    // Everything still in flight after this cycle's response is stale.
    if (bus.redirect_valid) begin
      fetch_pc_d = tgt;
      drop_d     = pend_q - CW'(bus.rsp_valid);
      state_d    = tgt_mis ? ST_HALT : ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      pend_q     <= '0;
      drop_q     <= '0;
      state_q    <= ST_RUN;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pend_q     <= pend_d;
      drop_q     <= drop_d;
      state_q    <= state_d;
    end
  end

  ysyx_25060170_sync_fifo #(.W(XLEN), .DEPTH(FIFO_DEPTH)) u_addr_q (
    .clk      (clk),
    .rst      (rst),
    .push     (req_fire),
    .push_dat (fetch_pc_q),
    .pop      (aq_pop),
    .flush    (bus.redirect_valid),
    .head_dat (aq_head),
    .cnt      (aq_cnt)
  );

  ysyx_25060170_sync_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_inst_q (
    .clk      (clk),
    .rst      (rst),
    .push     (fq_push),
    .push_dat (ent_push),
    .pop      (bus.inst_valid & bus.inst_ready),
    .flush    (bus.redirect_valid),
    .head_dat (ent_head),
    .cnt      (cnt)
  );

  assign {bus.inst, bus.inst_pc, fl_head} = ent_head;
  assign bus.inst_valid    = cnt != '0;
  assign bus.inst_err      = fl_head.err;
  assign bus.inst_misalign = fl_head.misalign;
endmodule

// File: tb/tb_ysyx_25060170_ifu_prefetch.sv
// Directed bench for the prefetch IFU: streaming, credit stall, redirect flushes, misaligned redirect, reset.
// Memory model answers one cycle after acceptance when enabled, in order, data = ~addr.
module tb_ysyx_25060170_ifu_prefetch;
  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   nf;
  logic last_fire;
  logic [31:0] mq[$];
  localparam logic [31:0] ERR_ADDR = 32'h8000_0004;

  ysyx_25060170_ifu_prefetch_if #(.XLEN(32)) bus ();

  ysyx_25060170_ifu_prefetch #(.XLEN(32), .RESET_PC(32'h8000_0000), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_rsp(input bit en);
    if (en && mq.size() > 0) begin
      bus.rsp_valid = 1'b1;
      bus.rsp_data  = ~mq[0];
      bus.rsp_err   = (mq[0] == ERR_ADDR);
      void'(mq.pop_front());
    end else begin
      bus.rsp_valid = 1'b0;
      bus.rsp_data  = '0;
      bus.rsp_err   = 1'b0;
    end
    #1;
  endtask

  task automatic tick();
    logic [31:0] a;
    last_fire = bus.req_valid && bus.req_ready;
    a = bus.req_addr;
    @(posedge clk);
    if (last_fire) mq.push_back(a);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.req_ready      = 1'b1;
    bus.rsp_valid      = 1'b0;
    bus.rsp_data       = '0;
    bus.rsp_err        = 1'b0;
    bus.inst_ready     = 1'b1;

    @(negedge clk);
    #1;
    chk("rst_req_valid", 32'(bus.req_valid), 32'd0);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_inst", bus.inst, 32'd0);
    chk("rst_inst_pc", bus.inst_pc, 32'd0);
    chk("rst_inst_err", 32'(bus.inst_err), 32'd0);
    chk("rst_inst_misalign", 32'(bus.inst_misalign), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Streaming, one fetch per cycle; fault on 0x80000004 only.
    for (int i = 0; i < 8; i++) begin
      set_rsp(1);
      chk("stream_req_valid", 32'(bus.req_valid), 32'd1);
      chk("stream_req_addr", bus.req_addr, 32'h8000_0000 + 32'(4 * i));
      if (i >= 2) begin
        chk("stream_inst_valid", 32'(bus.inst_valid), 32'd1);
        chk("stream_inst_pc", bus.inst_pc, 32'h8000_0000 + 32'(4 * (i - 2)));
        chk("stream_inst", bus.inst, ~(32'h8000_0000 + 32'(4 * (i - 2))));
        chk("stream_inst_err", 32'(bus.inst_err), (i == 3) ? 32'd1 : 32'd0);
      end
      tick();
    end
    bus.req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin set_rsp(1); tick(); end
    set_rsp(1);
    chk("drain_inst_valid", 32'(bus.inst_valid), 32'd0);

    // Credit stall with the IDU blocked.
    bus.req_ready  = 1'b1;
    bus.inst_ready = 1'b0;
    nf = 0;
    for (int i = 0; i < 6; i++) begin
      set_rsp(1);
      tick();
      if (last_fire) nf++;
    end
    bus.inst_ready = 1'b1;
    set_rsp(1);
    chk("stall_fire_count", 32'(nf), 32'd4);
    chk("stall_req_valid", 32'(bus.req_valid), 32'd0);
    chk("stall_inst_pc", bus.inst_pc, 32'h8000_0020);
    tick();
    bus.req_ready = 1'b0;
    set_rsp(1);
    chk("resume_req_valid", 32'(bus.req_valid), 32'd1);
    chk("resume_req_addr", bus.req_addr, 32'h8000_0030);
    chk("resume_inst_pc", bus.inst_pc, 32'h8000_0024);
    tick();
    for (int i = 0; i < 4; i++) begin set_rsp(1); tick(); end

    // Three outstanding, then redirect; stale responses must vanish.
    bus.req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin set_rsp(0); tick(); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_1000;
    set_rsp(0);
    chk("redir_req_valid", 32'(bus.req_valid), 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    set_rsp(1);
    chk("redir_new_req_valid", 32'(bus.req_valid), 32'd1);
    chk("redir_new_req_addr", bus.req_addr, 32'h8000_1000);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_rsp(1);
      chk("stale_inst_valid", 32'(bus.inst_valid), 32'd0);
      tick();
    end

    // Redirect coinciding with a response and an IDU pop.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_2000;
    set_rsp(1);
    chk("redir2_inst_valid", 32'(bus.inst_valid), 32'd1);
    chk("redir2_inst_pc", bus.inst_pc, 32'h8000_1000);
    chk("redir2_req_valid", 32'(bus.req_valid), 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    set_rsp(1);
    chk("redir2_fifo_empty", 32'(bus.inst_valid), 32'd0);
    chk("redir2_req_addr", bus.req_addr, 32'h8000_2000);
    tick();
    set_rsp(1); tick();
    set_rsp(1);
    chk("redir2_stale_inst_valid", 32'(bus.inst_valid), 32'd0);
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0102;
    set_rsp(1);
    chk("redir2_first_valid", 32'(bus.inst_valid), 32'd1);
    chk("redir2_first_pc", bus.inst_pc, 32'h8000_2000);
    tick();
    bus.redirect_valid = 1'b0;

`ifdef YSYX_25060170_IFU_MISALIGN_CHK_EN
    set_rsp(1);
    chk("mis_req_valid", 32'(bus.req_valid), 32'd0);
    chk("mis_inst_valid", 32'(bus.inst_valid), 32'd1);
    chk("mis_flag", 32'(bus.inst_misalign), 32'd1);
    chk("mis_inst_pc", bus.inst_pc, 32'h8000_0102);
    chk("mis_inst", bus.inst, 32'd0);
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0100;
    set_rsp(1);
    chk("halt_req_valid", 32'(bus.req_valid), 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
`else
    set_rsp(1);
    chk("align_req_valid", 32'(bus.req_valid), 32'd1);
    chk("align_req_addr", bus.req_addr, 32'h8000_0100);
    chk("align_inst_misalign", 32'(bus.inst_misalign), 32'd0);
    tick();
`endif

    begin : wait_first
      for (int k = 0; k < 10; k++) begin
        set_rsp(1);
        if (bus.inst_valid) disable wait_first;
        tick();
      end
    end
    chk("target_inst_valid", 32'(bus.inst_valid), 32'd1);
    chk("target_inst_pc", bus.inst_pc, 32'h8000_0100);
    chk("target_inst", bus.inst, ~32'h8000_0100);
    chk("target_inst_misalign", 32'(bus.inst_misalign), 32'd0);

    // Reset mid-operation clears outputs immediately.
    rst = 1'b0;
    #1;
    chk("midrst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("midrst_req_valid", 32'(bus.req_valid), 32'd0);
    chk("midrst_inst_pc", bus.inst_pc, 32'd0);
    mq.delete();
    set_rsp(0);
    tick();
    rst = 1'b1;
    #1;
    chk("post_rst_req_valid", 32'(bus.req_valid), 32'd1);
    chk("post_rst_req_addr", bus.req_addr, 32'h8000_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
